// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - 7-segment pattern constants and segment-to-BCD decode shared by driver and decoder
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Returns {err, bcd}; a dark digit is a legal blank, anything else unknown is an error.
  function automatic logic [4:0] seg_to_bcd(input logic [6:0] seg);
    case (seg)
      SEG_0:     return {1'b0, 4'd0};
      SEG_1:     return {1'b0, 4'd1};
      SEG_2:     return {1'b0, 4'd2};
      SEG_3:     return {1'b0, 4'd3};
      SEG_4:     return {1'b0, 4'd4};
      SEG_5:     return {1'b0, 4'd5};
      SEG_6:     return {1'b0, 4'd6};
      SEG_7:     return {1'b0, 4'd7};
      SEG_8:     return {1'b0, 4'd8};
      SEG_9:     return {1'b0, 4'd9};
      SEG_BLANK: return {1'b0, BCD_BLANK};
      default:   return {1'b1, BCD_BLANK};
    endcase
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// rtl/seg7_to_bcd.sv - combinational active-high segment pattern to BCD decoder
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_err
);

  logic [4:0] w_dec;

  assign w_dec = seg_to_bcd(i_seg);
  assign o_bcd = w_dec[3:0];
  assign o_err = w_dec[4];

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - reads a multiplexed 4-digit 7-segment scan back into coherent BCD frames
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int COM_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_com_in,
  input  logic [7:0]  i_seg_in,
  output logic [15:0] o_digit_bcd,
  output logic [3:0]  o_digit_dp,
  output logic [3:0]  o_digit_err,
  output logic        o_frame_strobe,
  output logic        o_frame_valid,
  output logic        o_stale
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_CAP = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    r_com_s1, r_com_s2, r_com_prev;
  logic [7:0]    r_seg_s1, r_seg_s2, r_seg_prev;
  logic [SW-1:0] r_settle;
  logic [TW-1:0] r_timeout;
  logic [3:0]    r_mask;
  logic [15:0]   r_stage_bcd;
  logic [3:0]    r_stage_dp, r_stage_err;
  logic [15:0]   r_digit_bcd;
  logic [3:0]    r_digit_dp, r_digit_err;
  logic          r_frame_strobe, r_frame_valid, r_stale;

  logic [3:0] w_com;
  logic [7:0] w_seg;
  logic       w_changed, w_onehot, w_capture, w_frame_done, w_to_sat;
  logic [1:0] w_idx;
  logic [3:0] w_bcd, w_mask_base, w_mask_next;
  logic       w_err;

  assign w_com = (COM_ACTIVE_LOW != 0) ? ~r_com_s2 : r_com_s2;
  assign w_seg = (SEG_ACTIVE_LOW != 0) ? ~r_seg_s2 : r_seg_s2;

  assign w_changed = (w_com != r_com_prev) || (w_seg != r_seg_prev);
  assign w_onehot  = (w_com != 4'b0000) && ((w_com & (w_com - 4'd1)) == 4'b0000);
  // Settle saturates past SETTLE_CAP, so this fires once per dwell.
  assign w_capture = !w_changed && (r_settle == SETTLE_CAP) && w_onehot;

  assign w_frame_done = (r_mask == 4'b1111);
  assign w_to_sat     = !w_capture && (r_timeout == TO_LAST);

  always_comb begin
    w_idx = 2'd3;
    case (w_com)
      4'b0001: w_idx = 2'd0;
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      default: w_idx = 2'd3;
    endcase
  end

  always_comb begin
    w_mask_base = (w_frame_done || w_to_sat) ? 4'b0000 : r_mask;
    w_mask_next = w_capture ? (w_mask_base | w_com) : w_mask_base;
  end

  seg7_to_bcd u_dec (
    .i_seg (w_seg[6:0]),
    .o_bcd (w_bcd),
    .o_err (w_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_com_s1       <= '0;
      r_com_s2       <= '0;
      r_com_prev     <= '0;
      r_seg_s1       <= '0;
      r_seg_s2       <= '0;
      r_seg_prev     <= '0;
      r_settle       <= '0;
      r_timeout      <= '0;
      r_mask         <= '0;
      r_stage_bcd    <= '0;
      r_stage_dp     <= '0;
      r_stage_err    <= '0;
      r_digit_bcd    <= '0;
      r_digit_dp     <= '0;
      r_digit_err    <= '0;
      r_frame_strobe <= 1'b0;
      r_frame_valid  <= 1'b0;
      r_stale        <= 1'b0;
    end else begin
      r_com_s1   <= i_com_in;
      r_com_s2   <= r_com_s1;
      r_seg_s1   <= i_seg_in;
      r_seg_s2   <= r_seg_s1;
      r_com_prev <= w_com;
      r_seg_prev <= w_seg;

      if (w_changed) begin
        r_settle <= '0;
      end else if (r_settle != SETTLE_MAX) begin
        r_settle <= r_settle + SW'(1);
      end

      if (w_capture) begin
        r_stage_bcd[int'(w_idx)*4 +: 4] <= w_bcd;
        r_stage_dp[w_idx]               <= w_seg[7];
        r_stage_err[w_idx]              <= w_err;
        r_timeout                       <= '0;
        r_stale                         <= 1'b0;
      end else if (r_timeout != TO_MAX) begin
        r_timeout <= r_timeout + TW'(1);
      end

      r_mask         <= w_mask_next;
      r_frame_strobe <= w_frame_done;

      if (w_frame_done) begin
        r_digit_bcd   <= r_stage_bcd;
        r_digit_dp    <= r_stage_dp;
        r_digit_err   <= r_stage_err;
        r_frame_valid <= 1'b1;
      end

      if (w_to_sat) begin
        r_stale       <= 1'b1;
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign o_digit_bcd    = r_digit_bcd;
  assign o_digit_dp     = r_digit_dp;
  assign o_digit_err    = r_digit_err;
  assign o_frame_strobe = r_frame_strobe;
  assign o_frame_valid  = r_frame_valid;
  assign o_stale        = r_stale;

endmodule
